// File: rtl/io_switch_pkg.sv
// Shared types and helpers for the N-port streaming crossbar.
package io_switch_pkg;

    localparam int   MAX_PORT_W = 8;
    localparam logic RESET_EN   = 1'b1;

    typedef struct packed {
        logic                  en;
        logic [MAX_PORT_W-1:0] sel;
    } route_entry_t;

    function automatic int port_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_switch_skid_fifo.sv
// Two-entry output buffer: registered head drives the output directly.
module io_switch_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [1:0]            count_r;
    logic                  pop_s;

    assign pop_s     = (count_r != 2'd0) && pop_ready;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign count     = count_r;

    // Storage and occupancy; upstream never pushes into a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_switch_nxn.sv
// N-port valid/ready crossbar with per-output routing, broadcast and
// drain-safe route changes.
module io_switch_nxn
    import io_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = port_w(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORT_W-1:0]               ctrl_addr,
    input  logic                            ctrl_wr_en,
    input  logic [PORT_W:0]                 ctrl_wr_data,
    output logic [NUM_PORTS-1:0]            route_pending,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready
);

    route_entry_t                     route_r      [NUM_PORTS];
    route_entry_t                     pend_entry_r [NUM_PORTS];
    logic [NUM_PORTS-1:0]             route_pending_r;
    route_entry_t                     wr_entry_s;
    logic [NUM_PORTS-1:0]             wr_hit_s;
    logic [NUM_PORTS*NUM_PORTS-1:0]   sub_s;
    logic [NUM_PORTS-1:0]             has_sub_s;
    logic [NUM_PORTS-1:0]             full_sub_s;
    logic [NUM_PORTS-1:0]             xfer_s;
    logic [NUM_PORTS-1:0]             push_s;
    logic [DATA_WIDTH-1:0]            in_arr_s     [NUM_PORTS];
    logic [DATA_WIDTH-1:0]            push_data_s  [NUM_PORTS];
    logic [1:0]                       count_s      [NUM_PORTS];

    assign wr_entry_s    = '{en: ctrl_wr_data[PORT_W], sel: MAX_PORT_W'(ctrl_wr_data[PORT_W-1:0])};
    assign route_pending = route_pending_r;
    assign in_ready      = {NUM_PORTS{rst}} & has_sub_s & ~full_sub_s;
    assign xfer_s        = in_valid & in_ready;

    // Subscription matrix (bit o*N+i: output o listens to input i) and its per-input reduction.
    always_comb begin
        sub_s      = '0;
        has_sub_s  = '0;
        full_sub_s = '0;
        wr_hit_s   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            wr_hit_s[o] = ctrl_wr_en && (ctrl_addr == PORT_W'(o));
            for (int i = 0; i < NUM_PORTS; i++) begin
                sub_s[o*NUM_PORTS+i] = route_r[o].en && !route_pending_r[o] &&
                                       (route_r[o].sel == MAX_PORT_W'(i));
                has_sub_s[i]  = has_sub_s[i] | sub_s[o*NUM_PORTS+i];
                full_sub_s[i] = full_sub_s[i] | (sub_s[o*NUM_PORTS+i] & (count_s[o] == 2'd2));
            end
        end
    end

    // A transfer on an input pushes into every subscribed output at the same edge.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            push_s[o]      = |(sub_s[o*NUM_PORTS +: NUM_PORTS] & xfer_s);
            push_data_s[o] = in_arr_s[route_r[o].sel[PORT_W-1:0]];
        end
    end

    // Routing table: a write parks in pending; the swap waits for the output to drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                route_r[o]      <= '{en: RESET_EN, sel: MAX_PORT_W'(o)};
                pend_entry_r[o] <= '{en: RESET_EN, sel: MAX_PORT_W'(o)};
            end
            route_pending_r <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (wr_hit_s[o]) begin
                    pend_entry_r[o]    <= wr_entry_s;
                    route_pending_r[o] <= 1'b1;
                end else if (route_pending_r[o] && (count_s[o] == 2'd0)) begin
                    route_r[o]         <= pend_entry_r[o];
                    route_pending_r[o] <= 1'b0;
                end else begin
                    route_pending_r[o] <= route_pending_r[o];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign in_arr_s[p] = in_data[p*DATA_WIDTH +: DATA_WIDTH];

        io_switch_skid_fifo #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[p]),
            .push_data (push_data_s[p]),
            .pop_ready (out_ready[p]),
            .out_valid (out_valid[p]),
            .out_data  (out_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .count     (count_s[p])
        );
    end

endmodule

// File: tb/tb_io_switch_nxn.sv
// Directed bench for io_switch_nxn (4 ports, 32-bit payload).
module tb_io_switch_nxn;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int PW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [PW-1:0]      ctrl_addr;
    logic               ctrl_wr_en;
    logic [PW:0]        ctrl_wr_data;
    logic [NP-1:0]      route_pending;
    logic [NP*DW-1:0]   in_data;
    logic [NP-1:0]      in_valid;
    logic [NP-1:0]      in_ready;
    logic [NP*DW-1:0]   out_data;
    logic [NP-1:0]      out_valid;
    logic [NP-1:0]      out_ready;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    io_switch_nxn #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_addr     (ctrl_addr),
        .ctrl_wr_en    (ctrl_wr_en),
        .ctrl_wr_data  (ctrl_wr_data),
        .route_pending (route_pending),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] od(input int o);
        return out_data[o*DW +: DW];
    endfunction

    task automatic set_in(input int i, input logic [DW-1:0] d, input logic v);
        in_data[i*DW +: DW] = d;
        in_valid[i]         = v;
    endtask

    task automatic wr_route(input int a, input logic [PW:0] d);
        ctrl_addr    = PW'(a);
        ctrl_wr_data = d;
        ctrl_wr_en   = 1'b1;
        tick();
        ctrl_wr_en   = 1'b0;
    endtask

    initial begin
        int            exp_v [NP];
        int            nxt;
        int            pops;
        logic [15:0]   rdy_hist;

        rst = 1'b0; ctrl_addr = '0; ctrl_wr_en = 1'b0; ctrl_wr_data = '0;
        in_data = '0; in_valid = '0; out_ready = 4'hF;
        tick(); tick();
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_pending", route_pending, 4'h0);
        check("rst_in_ready", in_ready, 4'h0);
        check("rst_out_data", out_data, 128'h0);
        rst = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 4'hF);

        // Identity routing
        set_in(2, 32'hA5A50002, 1'b1);
        check("id_in_ready2", in_ready[2], 1'b1);
        tick();
        set_in(2, 32'h0, 1'b0);
        check("id_out_valid", out_valid, 4'b0100);
        check("id_out_data2", od(2), 32'hA5A50002);
        tick();
        check("id_drained", out_valid, 4'h0);

        // Broadcast of input 2 to outputs 0,1,3 (plus 2 by identity)
        wr_route(0, 3'b110); wr_route(1, 3'b110); wr_route(3, 3'b110); tick();
        check("bc_committed", route_pending, 4'h0);
        check("bc_in_ready", in_ready, 4'b0100);
        nxt = 1; rdy_hist = '0;
        for (int o = 0; o < NP; o++) exp_v[o] = 1;
        for (int c = 1; c <= 16; c++) begin
            out_ready = (c >= 3 && c <= 6) ? 4'b1101 : 4'hF;
            set_in(2, 32'(nxt), nxt <= 8);
            #4;
            rdy_hist[c-1] = in_ready[2];
            if (in_valid[2] && in_ready[2]) nxt++;
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    check($sformatf("bc_data_o%0d", o), od(o), 64'(exp_v[o]));
                    exp_v[o]++;
                end
            end
            tick();
        end
        set_in(2, 32'h0, 1'b0);
        out_ready = 4'hF;
        check("bc_sent", nxt, 9);
        for (int o = 0; o < NP; o++) check($sformatf("bc_count_o%0d", o), exp_v[o], 9);
        check("bc_rdy_c3", rdy_hist[2], 1'b1);
        check("bc_rdy_c4", rdy_hist[3], 1'b0);
        check("bc_rdy_c7", rdy_hist[6], 1'b0);
        check("bc_rdy_c8", rdy_hist[7], 1'b1);
        check("bc_empty", out_valid, 4'h0);

        // Drain-safe reroute of output 0 to input 1
        wr_route(0, 3'b100); wr_route(1, 3'b101); wr_route(3, 3'b111); tick();
        out_ready = 4'b1110;
        set_in(0, 32'h10, 1'b1); tick();
        set_in(0, 32'h11, 1'b1); tick();
        set_in(0, 32'h0, 1'b0);
        check("rr_full_data", od(0), 32'h10);
        check("rr_full_ready0", in_ready[0], 1'b0);
        wr_route(0, 3'b101);
        check("rr_pending", route_pending, 4'b0001);
        check("rr_ready_pend", in_ready, 4'b1110);
        out_ready = 4'hF;
        tick();
        check("rr_pop2", od(0), 32'h11);
        tick();
        check("rr_empty", out_valid[0], 1'b0);
        check("rr_still_pend", route_pending[0], 1'b1);
        tick();
        check("rr_commit", route_pending, 4'h0);
        check("rr_ready_new", in_ready, 4'b1110);
        set_in(1, 32'h20, 1'b1); tick();
        set_in(1, 32'h0, 1'b0);
        check("rr_new_valid", out_valid, 4'b0011);
        check("rr_new_o0", od(0), 32'h20);
        check("rr_new_o1", od(1), 32'h20);
        tick();

        // Disable output 3 and hold a beat on input 3
        wr_route(3, 3'b011); tick();
        set_in(3, 32'h33, 1'b1);
        for (int c = 0; c < 10; c++) begin
            check("dis_ready3", in_ready[3], 1'b0);
            check("dis_valid3", out_valid[3], 1'b0);
            tick();
        end
        wr_route(3, 3'b111); tick();
        check("en_ready3", in_ready[3], 1'b1);
        tick();
        set_in(3, 32'h0, 1'b0);
        check("en_valid3", out_valid[3], 1'b1);
        check("en_data3", od(3), 32'h33);
        tick();
        check("en_once3", out_valid[3], 1'b0);

        // Throughput with identity routing
        wr_route(0, 3'b100); tick();
        pops = 0;
        for (int k = 0; k <= 100; k++) begin
            for (int i = 0; i < NP; i++) set_in(i, 32'((i << 16) | k), k < 100);
            if (k == 0) check("tp_first", out_valid, 4'h0);
            else begin
                check("tp_valid", out_valid, 4'hF);
                for (int i = 0; i < NP; i++) check("tp_data", od(i), 64'((i << 16) | (k - 1)));
            end
            if (k < 100) check("tp_ready", in_ready, 4'hF);
            pops += $countones(out_valid & out_ready);
            tick();
        end
        in_valid = '0;
        check("tp_pops", pops, 400);
        check("tp_done", out_valid, 4'h0);

        // Reset with every buffer full and a route pending
        out_ready = 4'h0;
        for (int i = 0; i < NP; i++) set_in(i, 32'hC0 + 32'(i), 1'b1);
        tick(); tick();
        in_valid = '0;
        check("mr_full_ready", in_ready, 4'h0);
        check("mr_full_valid", out_valid, 4'hF);
        wr_route(2, 3'b100);
        check("mr_pending", route_pending, 4'b0100);
        rst = 1'b0;
        tick();
        check("mr_out_valid", out_valid, 4'h0);
        check("mr_pending_clr", route_pending, 4'h0);
        check("mr_in_ready", in_ready, 4'h0);
        check("mr_out_data", out_data, 128'h0);
        rst = 1'b1; out_ready = 4'hF;
        #1;
        check("mr_identity", in_ready, 4'hF);
        set_in(2, 32'hBEEF, 1'b1); tick();
        set_in(2, 32'h0, 1'b0);
        check("mr_beat_valid", out_valid, 4'b0100);
        check("mr_beat_data", od(2), 32'hBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
